frame_fuse_accum: RTL
=====================

# frame_fuse_accum

Parametrised multi-frame pixel fusion engine on AXI4-Stream. It accepts 2^k consecutive image frames on the slave stream and accumulates them per pixel in an internal frame-sized buffer. While the last frame of the group streams in, it emits one fused frame (rounded average or per-pixel maximum) on the master stream. It is the next generation of the fixed-count fusion stage between the camera DMA and the downstream filter, adding runtime fuse count, runtime mode, a pixel-width parameter and framing checks.

## Interface
- PIXELS_PER_BEAT, 16, pixels per stream beat
- PIXEL_WIDTH, 8, bits per unsigned pixel
- IMAGE_DIM, 512, square frame side; BEATS = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT; BEATS must be at least 2
- MAX_FUSE_LOG2, 4, maximum log2 of the fuse count
- DATA_WIDTH, PIXEL_WIDTH*PIXELS_PER_BEAT, stream data width
- ACC_W (localparam), PIXEL_WIDTH+MAX_FUSE_LOG2, accumulator width per pixel
- s_axis_aclk  in  1  single clock; all logic on its rising edge
- s_axis_areset  in  1  synchronous, active-high reset
- cfg_fuse_log2  in  clog2(MAX_FUSE_LOG2+1)  N = 2^cfg_fuse_log2 frames per group; values above MAX_FUSE_LOG2 clamp to MAX_FUSE_LOG2
- cfg_mode  in  1  0 = rounded average, 1 = per-pixel max
- s_axis_tdata  in  DATA_WIDTH  pixel p occupies bits [p*PIXEL_WIDTH +: PIXEL_WIDTH]
- s_axis_tvalid  in  1; s_axis_tready  out  1; s_axis_tlast  in  1  asserted on the last beat of each input frame
- m_axis_tdata  out  DATA_WIDTH; m_axis_tvalid  out  1; m_axis_tready  in  1; m_axis_tlast  out  1
- frame_err  out  1  one-cycle pulse on a tlast/beat-position mismatch
- busy  out  1  high while a group is partially received or the pipeline holds data

## Operation
- Counters: beat_cnt (0..BEATS-1) and frame_cnt (0..N-1). Both advance only on an input handshake. beat_cnt wraps to 0 and increments frame_cnt. frame_cnt wraps to 0 after N-1.
- cfg_fuse_log2 and cfg_mode are captured on the handshake of frame 0, beat 0. They are held for the whole group, so changes mid-group have no effect.
- Framing is defined only by the internal beat_cnt; s_axis_tlast never resynchronises it.
- frame_err pulses when tlast=1 with beat_cnt≠BEATS-1, or tlast=0 with beat_cnt=BEATS-1. Processing continues normally.
- Accumulator RAM: BEATS words × PIXELS_PER_BEAT×ACC_W bits, one synchronous read port and one write port. Contents are not reset.
- Pipeline stage S1 is entered on handshake:
  - The RAM read is issued at address beat_cnt.
  - Input data, frame index and beat index are registered.
  - RAM read data holds while S1 is stalled.
- Combine in S1, per pixel, with prior value a taken from the RAM read:
  - Frame 0: a is 0, and the RAM output is ignored.
  - Average mode: a + x, full ACC_W width, no overflow possible.
  - Max mode: max(a, x) in the low PIXEL_WIDTH bits, upper bits zero.
- Non-final frames: the combined word is written to the RAM at the S1 beat index when S1 retires. Nothing is output.
- Final frame (frame N-1): the combined word is not written back.
  - Average mode output: (sum + (N>>1)) >> cfg_fuse_log2, round half up, which always fits PIXEL_WIDTH.
  - Max mode output: the max value.
  - The result is loaded into the m_axis registers. m_axis_tlast = 1 when the S1 beat index is BEATS-1.
- N=1: every frame is both frame 0 and final, so output equals input (average: x+0 >> 0).
- Reset mid-group: counters, S1 and output are cleared. The next accepted beat is frame 0, beat 0, and stale RAM is harmless because frame 0 ignores it.

## Timing
- Reset values: s_axis_tready 0 during reset and 1 afterwards; m_axis_tvalid 0, m_axis_tdata 0, m_axis_tlast 0, frame_err 0, busy 0; counters 0; S1 empty.
- S1 may advance when it holds a non-final beat, or when m_axis_tvalid=0, or when m_axis_tready=1.
- s_axis_tready = ~S1_valid | S1_advance. It is combinational from m_axis_tready; no other input-to-output combinational path.
- Latency: a final-frame beat accepted in cycle c appears on m_axis in cycle c+2 when there is no backpressure.
- Throughput: 1 beat per cycle in both accumulate and output frames.
- m_axis_tdata and m_axis_tlast are stable while m_axis_tvalid=1 and m_axis_tready=0.
- RAM hazard: the write for beat b (cycle c+1) never targets the address read in the same cycle (b+1 mod BEATS), which is guaranteed by BEATS ≥ 2.
- Boundary between groups: frame 0 of the next group is accepted while the last output beats of the previous group drain.
- frame_err is registered; it is asserted in cycle c+1 for a bad beat accepted in cycle c.
- busy = (frame_cnt≠0) | (beat_cnt≠0) | S1_valid | m_axis_tvalid.

## Test plan
- Average with IMAGE_DIM=8, PIXELS_PER_BEAT=4, cfg_fuse_log2=2:
  - Stimulus: four frames with all pixels 10, 20, 30, 41.
  - Response: one output frame, all pixels 25 ((101+2)>>2), m_axis_tlast on beat 15 only, no output during frames 0-2.
- Max mode, N=4:
  - Stimulus: pixel p of frame f = (p*37+f*91) mod 256.
  - Response: output equals the per-pixel maximum; no write-back corruption across the following group.
- N=1:
  - Stimulus: ramp data.
  - Response: output equals input, delayed 2 cycles, at 1 beat/cycle.
- Backpressure in the final frame:
  - Stimulus: m_axis_tready toggled randomly (50%).
  - Response: s_axis_tready falls within the same cycle; no beat lost or duplicated; data held stable while stalled.
- Framing error:
  - Stimulus: s_axis_tlast asserted on beat 7 of frame 1.
  - Response: frame_err pulses exactly once; output values and tlast position are unchanged.
- Reset mid-group:
  - Stimulus: s_axis_areset asserted for 1 cycle during frame 2 of N=4, then four frames of value 100 sent.
  - Response: output all 100; busy 0 immediately after reset.

Source files
------------

// File: rtl/frame_fuse_accum.sv
// Multi-frame pixel fusion: accumulates 2^k frames per pixel in a frame-sized RAM
// and emits a rounded-average or per-pixel-max frame while the last frame streams in.
module frame_fuse_accum #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int PIXEL_WIDTH     = 8,
    parameter int IMAGE_DIM       = 512,
    parameter int MAX_FUSE_LOG2   = 4,
    parameter int DATA_WIDTH      = PIXEL_WIDTH * PIXELS_PER_BEAT,
    localparam int CFG_W          = (MAX_FUSE_LOG2 > 0) ? $clog2(MAX_FUSE_LOG2 + 1) : 1
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_areset,
    input  logic [CFG_W-1:0]      cfg_fuse_log2,
    input  logic                  cfg_mode,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int BEATS  = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int ACC_W  = PIXEL_WIDTH + MAX_FUSE_LOG2;
    localparam int BC_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int FC_W   = (MAX_FUSE_LOG2 > 0) ? MAX_FUSE_LOG2 : 1;
    localparam int WORD_W = ACC_W * PIXELS_PER_BEAT;
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);

    function automatic logic [CFG_W-1:0] clamp_log2(input logic [CFG_W-1:0] v);
        if (int'(v) > MAX_FUSE_LOG2) return CFG_W'(MAX_FUSE_LOG2);
        return v;
    endfunction

    function automatic logic [ACC_W-1:0] combine_pix(input logic [ACC_W-1:0] prior,
                                                      input logic [PIXEL_WIDTH-1:0] x,
                                                      input logic first,
                                                      input logic mode);
        logic [ACC_W-1:0] a;
        a = first ? '0 : prior;
        if (mode) return (a[PIXEL_WIDTH-1:0] > x) ? ACC_W'(a[PIXEL_WIDTH-1:0]) : ACC_W'(x);
        return a + ACC_W'(x);
    endfunction

    // Round half up; the sum of N pixels shifted by log2(N) always fits a pixel.
    function automatic logic [PIXEL_WIDTH-1:0] round_avg(input logic [ACC_W-1:0] sum,
                                                          input logic [CFG_W-1:0] sh);
        logic [ACC_W:0] half;
        logic [ACC_W:0] tot;
        half = (ACC_W + 1)'(1) << sh;
        half = half >> 1;
        tot  = {1'b0, sum} + half;
        tot  = tot >> sh;
        return tot[PIXEL_WIDTH-1:0];
    endfunction

    logic [WORD_W-1:0]     acc_mem [BEATS];

    logic [BC_W-1:0]       beat_cnt;
    logic [FC_W-1:0]       frame_cnt;
    logic [CFG_W-1:0]      grp_log2;
    logic                  grp_mode;
    logic                  group_start;
    logic [CFG_W-1:0]      eff_log2;
    logic                  eff_mode;
    logic [FC_W-1:0]       last_frame;
    logic                  hs;
    logic                  s1_adv;

    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic [BC_W-1:0]       beat_p1;
    logic                  first_p1;
    logic                  final_p1;
    logic                  mode_p1;
    logic [CFG_W-1:0]      log2_p1;
    logic [WORD_W-1:0]     rd_word_p1;
    logic [WORD_W-1:0]     comb_word;
    logic [DATA_WIDTH-1:0] fused;

    // The group's configuration is taken live on its very first beat, then held.
    always_comb begin
        group_start = (frame_cnt == '0) && (beat_cnt == '0);
        eff_log2    = group_start ? clamp_log2(cfg_fuse_log2) : grp_log2;
        eff_mode    = group_start ? cfg_mode : grp_mode;
        last_frame  = FC_W'((1 << eff_log2) - 1);
        s1_adv      = vld_p1 & (~final_p1 | ~m_axis_tvalid | m_axis_tready);
        s_axis_tready = ~s_axis_areset & (~vld_p1 | s1_adv);
        hs          = s_axis_tvalid & s_axis_tready;
        busy        = (frame_cnt != '0) | (beat_cnt != '0) | vld_p1 | m_axis_tvalid;
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            beat_cnt      <= '0;
            frame_cnt     <= '0;
            grp_log2      <= '0;
            grp_mode      <= 1'b0;
            vld_p1        <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (hs) begin
                frame_err <= s_axis_tlast ^ (beat_cnt == LAST_BEAT);
                if (group_start) begin
                    grp_log2 <= eff_log2;
                    grp_mode <= eff_mode;
                end
                if (beat_cnt == LAST_BEAT) begin
                    beat_cnt  <= '0;
                    frame_cnt <= (frame_cnt == last_frame) ? '0 : frame_cnt + FC_W'(1);
                end else begin
                    beat_cnt <= beat_cnt + BC_W'(1);
                end
                vld_p1 <= 1'b1;
            end else if (s1_adv) begin
                vld_p1 <= 1'b0;
            end
            if (s1_adv && final_p1) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= fused;
                m_axis_tlast  <= (beat_p1 == LAST_BEAT);
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    // ---- stage p1: input beat and its prior RAM word, held while stalled ----
    always_ff @(posedge s_axis_aclk) begin
        if (hs) begin
            data_p1    <= s_axis_tdata;
            beat_p1    <= beat_cnt;
            first_p1   <= (frame_cnt == '0);
            final_p1   <= (frame_cnt == last_frame);
            mode_p1    <= eff_mode;
            log2_p1    <= eff_log2;
            rd_word_p1 <= acc_mem[beat_cnt];
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s1_adv && !final_p1) acc_mem[beat_p1] <= comb_word;
    end

    always_comb begin
        comb_word = '0;
        fused     = '0;
        for (int p = 0; p < PIXELS_PER_BEAT; p++) begin
            comb_word[p*ACC_W +: ACC_W] = combine_pix(rd_word_p1[p*ACC_W +: ACC_W],
                                                      data_p1[p*PIXEL_WIDTH +: PIXEL_WIDTH],
                                                      first_p1, mode_p1);
            fused[p*PIXEL_WIDTH +: PIXEL_WIDTH] = mode_p1
                ? comb_word[p*ACC_W +: PIXEL_WIDTH]
                : round_avg(comb_word[p*ACC_W +: ACC_W], log2_p1);
        end
    end

endmodule
